// File: rtl/seqgen_pkg.sv
// Shared types for the NVRAM memory-cycle sequencer: FSM state encodings
// (also driven onto SeqState) and the latched operation type.
package seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACTIVE = 2'b10,
    DONE   = 2'b11
  } seqStateT;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } seqOpT;

  localparam int CNT_W = 3;

endpackage

// File: rtl/seqgen_width_counter.sv
// Strobe-width counter: loads a width, counts down to zero and holds there,
// flagging zero for the sequencer FSM.
module seqgen_width_counter
  import seqgen_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] loadVal,
  output logic [CNT_W-1:0] count,
  output logic             isZero
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/sequence_generator.sv
// NVRAM memory-cycle sequencer driving active-low /CE, /WE, /OE in a
// setup -> strobe -> recovery pattern. Optional macro: SEQGEN_EXTEND_EN.
module sequence_generator
  import seqgen_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] Delay,
  input  logic       Extend,
  input  logic       StartCycle,
  input  logic       ReadSeq,
  input  logic       WriteSeq,
  output logic       CE,
  output logic       WE,
  output logic       OE,
  output logic [1:0] SeqState
);

  seqStateT   state, nextState;
  seqOpT      op, nextOp;
  logic       loadCnt, decCnt;
  logic       cntZero;
  logic       extendEff;
  logic [2:0] cnt;
  logic       ceNext, weNext, oeNext;

`ifdef SEQGEN_EXTEND_EN
  assign extendEff = Extend;
`else
  assign extendEff = Extend & 1'b0;
`endif

  seqgen_width_counter uWidthCounter (
    .Clk     (Clk),
    .Reset   (Reset),
    .load    (loadCnt),
    .dec     (decCnt),
    .loadVal (Delay),
    .count   (cnt),
    .isZero  (cntZero)
  );

  always_comb begin
    nextState = state;
    nextOp    = op;
    loadCnt   = 1'b0;
    decCnt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (StartCycle && (ReadSeq || WriteSeq)) begin
          nextState = SETUP;
          nextOp    = ReadSeq ? OP_READ : OP_WRITE;
        end
      end
      SETUP: begin
        loadCnt   = 1'b1;
        nextState = ACTIVE;
      end
      ACTIVE: begin
        if (cntZero && !extendEff) nextState = DONE;
        else                       decCnt    = 1'b1;
      end
      DONE: begin
        if (!StartCycle) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they register on the same edge
  // as the state change; this keeps both strobes off whenever CE is high.
  always_comb begin
    ceNext = !((nextState == SETUP) || (nextState == ACTIVE));
    oeNext = !((nextState == ACTIVE) && (nextOp == OP_READ));
    weNext = !((nextState == ACTIVE) && (nextOp == OP_WRITE));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      op    <= OP_READ;
      CE    <= 1'b1;
      WE    <= 1'b1;
      OE    <= 1'b1;
    end else begin
      state <= nextState;
      op    <= nextOp;
      CE    <= ceNext;
      WE    <= weNext;
      OE    <= oeNext;
    end
  end

  assign SeqState = state;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: cycle-level behavioural model
// compared every cycle, plus directed literal checks and random stimulus.
module tb_sequence_generator;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] Delay = 3'd0;
  logic       Extend = 1'b0;
  logic       StartCycle = 1'b0;
  logic       ReadSeq = 1'b0;
  logic       WriteSeq = 1'b0;
  logic       CE, WE, OE;
  logic [1:0] SeqState;

  int tests = 0;
  int fails = 0;

  // model: phase 0 idle, 1 setup, 2 strobe, 3 recovery
  int mPhase = 0;
  bit mRead  = 1'b1;
  int mDelay = 0;
  int mAct   = 0;

  sequence_generator dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Delay      (Delay),
    .Extend     (Extend),
    .StartCycle (StartCycle),
    .ReadSeq    (ReadSeq),
    .WriteSeq   (WriteSeq),
    .CE         (CE),
    .WE         (WE),
    .OE         (OE),
    .SeqState   (SeqState)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit extendHonoured();
`ifdef SEQGEN_EXTEND_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic modelStep();
    bit ext;
    ext = Extend && extendHonoured();
    if (Reset) begin
      mPhase = 0;
      mRead  = 1'b1;
      mAct   = 0;
    end else begin
      case (mPhase)
        0: if (StartCycle && (ReadSeq || WriteSeq)) begin
             mPhase = 1;
             mRead  = ReadSeq;
           end
        1: begin
             mDelay = int'(Delay);
             mAct   = 0;
             mPhase = 2;
           end
        2: begin
             mAct++;
             if (mAct >= mDelay + 1 && !ext) mPhase = 3;
           end
        default: if (!StartCycle) mPhase = 0;
      endcase
    end
  endtask

  task automatic compareAll();
    int expCe, expOe, expWe;
    expCe = (mPhase == 1 || mPhase == 2) ? 0 : 1;
    expOe = (mPhase == 2 && mRead)  ? 0 : 1;
    expWe = (mPhase == 2 && !mRead) ? 0 : 1;
    check("CE", int'(CE), expCe);
    check("OE", int'(OE), expOe);
    check("WE", int'(WE), expWe);
    check("SeqState", int'(SeqState), mPhase);
    check("strobe_exclusive", int'(!WE && !OE), 0);
    check("strobe_without_ce", int'(CE && (!WE || !OE)), 0);
  endtask

  // one clock: model follows the edge, compare on the falling edge
  task automatic tick();
    @(posedge Clk);
    modelStep();
    @(negedge Clk);
    compareAll();
  endtask

  task automatic directedCycle(input bit isRead);
    int ceLow, oeLow, weLow, firstStrobe;
    int seqs[12];
    Delay = 3'd3; Extend = 1'b0;
    ReadSeq = isRead; WriteSeq = !isRead; StartCycle = 1'b1;
    ceLow = 0; oeLow = 0; weLow = 0; firstStrobe = -1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) begin ReadSeq = !isRead; WriteSeq = isRead; Delay = 3'd7; end
      seqs[i] = int'(SeqState);
      ceLow += int'(!CE);
      oeLow += int'(!OE);
      weLow += int'(!WE);
      if (firstStrobe < 0 && (!OE || !WE)) firstStrobe = i;
    end
    check(isRead ? "rd_ce_low" : "wr_ce_low", ceLow, 5);
    check(isRead ? "rd_oe_low" : "wr_oe_low", oeLow, isRead ? 4 : 0);
    check(isRead ? "rd_we_low" : "wr_we_low", weLow, isRead ? 0 : 4);
    check("strobe_start", firstStrobe, 1);
    check("seq_setup", seqs[0], 1);
    check("seq_active_first", seqs[1], 2);
    check("seq_active_last", seqs[4], 2);
    check("seq_done", seqs[5], 3);
    check("seq_done_held", seqs[11], 3);
    StartCycle = 1'b0; ReadSeq = 1'b0; WriteSeq = 1'b0;
    tick();
    check("seq_back_idle", int'(SeqState), 0);
  endtask

  initial begin
    int oeLow;
    // reset
    tick(); tick();
    check("rst_ce", int'(CE), 1);
    check("rst_we", int'(WE), 1);
    check("rst_oe", int'(OE), 1);
    check("rst_seq", int'(SeqState), 0);
    Reset = 1'b0;

    // idle
    repeat (20) tick();
    check("idle_seq", int'(SeqState), 0);

    // start with no select
    StartCycle = 1'b1;
    repeat (20) tick();
    check("nosel_seq", int'(SeqState), 0);
    check("nosel_ce", int'(CE), 1);
    StartCycle = 1'b0;
    tick();

    directedCycle(1'b1);
    directedCycle(1'b0);

    // Delay=0 minimum strobe, StartCycle dropped mid-cycle
    Delay = 3'd0; ReadSeq = 1'b1; StartCycle = 1'b1;
    tick();
    StartCycle = 1'b0;
    tick();
    check("min_strobe_oe", int'(OE), 0);
    tick();
    check("min_strobe_done", int'(SeqState), 3);
    tick();
    check("min_strobe_idle", int'(SeqState), 0);

    // Extend held through a read
    Delay = 3'd3; Extend = 1'b1; ReadSeq = 1'b1; StartCycle = 1'b1;
    oeLow = 0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      oeLow += int'(!OE);
      if (i == 17) Extend = 1'b0;
    end
    check("extend_oe_low", oeLow, extendHonoured() ? 16 : 4);
    StartCycle = 1'b0; ReadSeq = 1'b0;
    tick();

    // reset mid-cycle
    Delay = 3'd5; WriteSeq = 1'b1; StartCycle = 1'b1;
    repeat (3) tick();
    check("pre_rst_active", int'(SeqState), 2);
    Reset = 1'b1;
    tick();
    check("midrst_ce", int'(CE), 1);
    check("midrst_we", int'(WE), 1);
    check("midrst_seq", int'(SeqState), 0);
    Reset = 1'b0; StartCycle = 1'b0; WriteSeq = 1'b0;
    tick();

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      Reset      = ($urandom_range(0, 199) == 0);
      StartCycle = ($urandom_range(0, 9) < 7);
      ReadSeq    = $urandom_range(0, 1);
      WriteSeq   = $urandom_range(0, 1);
      Delay      = 3'($urandom_range(0, 7));
      Extend     = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

NVRAM memory-cycle sequencer. Given a start request and a read or write selection, it drives the active-low /CE, /WE and /OE strobes of an asynchronous NVRAM in a fixed setup → strobe → recovery pattern. The strobe width is programmable and can be stretched by a wait input. It sits between the bus/CPU interface logic and the external NVRAM pins.

## Interface
Parameters:
- none; all widths fixed.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Delay  in  3  strobe-width count; strobe lasts Delay+1 cycles.
- Extend  in  1  wait request; holds the strobe active while high.
- StartCycle  in  1  level request to run one memory cycle.
- ReadSeq  in  1  selects a read sequence.
- WriteSeq  in  1  selects a write sequence.
- CE  out  1  NVRAM chip enable, active low.
- WE  out  1  NVRAM write enable, active low.
- OE  out  1  NVRAM output enable, active low.
- SeqState  out  2  current state encoding, for debug and handshake.

## Operation
States, with SeqState value:
- IDLE 2'b00
  - CE=WE=OE=1.
  - If StartCycle && (ReadSeq || WriteSeq), go to SETUP.
  - Latch the op on that transition: read when ReadSeq=1 (read wins if both are high), otherwise write.
  - If StartCycle=1 with neither select high, stay in IDLE with all strobes inactive.
- SETUP 2'b01
  - CE=0, WE=OE=1. This is address setup and lasts exactly 1 cycle.
  - Load the counter with Delay, then go to ACTIVE.
- ACTIVE 2'b10
  - CE=0. OE=0 for a read or WE=0 for a write; the other strobe stays 1.
  - If counter==0 and Extend==0, go to DONE.
  - Otherwise decrement the counter, saturating at 0, and stay in ACTIVE.
- DONE 2'b11
  - CE=WE=OE=1. This is recovery.
  - Stay until StartCycle==0, then go to IDLE. Exactly one cycle runs per StartCycle assertion.

Rules:
- ReadSeq, WriteSeq and Delay are sampled only at their load points. Changes mid-cycle are ignored.
- A cycle that has started always completes. StartCycle going low during SETUP or ACTIVE does not abort it; the FSM passes through DONE to IDLE on the next cycle.
- WE and OE are never low at the same time. Neither is ever low while CE=1.
- Reset has priority over everything, including mid-cycle.
- Reset values: state IDLE, SeqState=00, CE=WE=OE=1, counter=0, op=read.

## Timing
- All outputs are registered and change only on a rising Clk edge, so they are glitch-free.
- Edge numbering: E1 is the first edge that samples StartCycle=1 with a valid select.
  - E1: SETUP, CE falls.
  - E2: ACTIVE, strobe falls.
  - E(3+Delay): DONE, CE and the strobe rise together.
- With Extend=0: CE is low for Delay+2 cycles and the strobe is low for Delay+1 cycles.
- Extend is sampled every ACTIVE cycle. Each cycle it is high adds one cycle once the counter reaches 0.
- Delay=0 gives a minimum strobe of 1 cycle.
- From DONE with StartCycle low, IDLE follows 1 cycle later. A new cycle needs StartCycle to be seen low at least once.

## Configuration
- SEQGEN_EXTEND_EN defined: Extend is honoured as described above.
- SEQGEN_EXTEND_EN not defined: Extend is ignored and the strobe is always exactly Delay+1 cycles. The port remains present.

## Structure
- Shared package seqgen_pkg holds:
  - the state localparams (IDLE, SETUP, ACTIVE, DONE) and their 2-bit encodings;
  - the op type (OP_READ, OP_WRITE).
- One sub-module, seqgen_width_counter: 3-bit load/decrement/zero-flag counter.
- The FSM and output registers stay in sequence_generator.

## Test plan
- Idle check: Reset then release, StartCycle=0, 20 clocks → CE=WE=OE=1 throughout and SeqState=00.
- No select: StartCycle=1, ReadSeq=WriteSeq=0, 20 clocks, then StartCycle=0 → strobes stay 1 and SeqState stays 00.
- Read, Delay=3:
  - Clock run: StartCycle=1, ReadSeq=1.
  - Required: CE low 5 cycles; OE low 4 cycles starting 1 cycle after CE falls; WE=1 throughout.
  - SeqState sequence: 01, 10 ×4, then 11 held until StartCycle=0, then 00.
- Write, Delay=3: same stimulus with WriteSeq=1 → WE low 4 cycles, OE=1 throughout; same CE and SeqState pattern.
- Extend, SEQGEN_EXTEND_EN defined:
  - Stimulus: Extend=1 before a read starts, Delay=3, released after 15 cycles in ACTIVE.
  - Required: OE remains low until the first edge sampling Extend=0, then DONE.
  - Repeat without the macro → OE low exactly 4 cycles.
- Reset mid-cycle: assert Reset during ACTIVE → next edge gives CE=WE=OE=1 and SeqState=00.
